// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel/window constants for the 5x5 window path
package img_pkg;

   localparam int PIX_W = 8;
   localparam int KSIZE = 5;
   localparam int WIN_W = KSIZE * KSIZE * PIX_W;

   // LSB of window element (row r, col c); row 0 is the oldest line
   function automatic int win_idx(input int r, input int c);
      return r * KSIZE * PIX_W + c * PIX_W;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of pixels, combinational read, synchronous write
module line_buffer
   import img_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wr_data,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   // No reset: stale contents are never exposed because output is gated by row >= 4
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - streaming 5x5 window generator over four line buffers
module window_gen_5x5
   import img_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [WIN_W-1:0] window
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(KSIZE - 1);

   logic [CW-1:0]    col_q, pos_c;
   logic [RW-1:0]    row_q, pos_r;
   logic             accept;
   logic [PIX_W-1:0] lb_rd   [KSIZE-1];
   logic [PIX_W-1:0] lb_wr   [KSIZE-1];
   logic [PIX_W-1:0] new_col [KSIZE];
   logic [PIX_W-1:0] win_q   [KSIZE][KSIZE];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A start-of-frame pixel is forced to (0,0) regardless of the counters
   assign pos_c = in_sof ? '0 : col_q;
   assign pos_r = in_sof ? '0 : row_q;

   // Line k ages into line k-1 at the same column on every accept
   for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
      if (k == KSIZE - 2) begin : g_top
         assign lb_wr[k] = in_pixel;
      end else begin : g_mid
         assign lb_wr[k] = lb_rd[k+1];
      end
      line_buffer #(
         .DEPTH (IMG_WIDTH),
         .AW    (CW)
      ) u_lb (
         .clk     (clk),
         .wr_en   (accept),
         .addr    (pos_c),
         .wr_data (lb_wr[k]),
         .rd_data (lb_rd[k])
      );
   end

   for (genvar r = 0; r < KSIZE; r++) begin : g_row
      if (r == KSIZE - 1) begin : g_new
         assign new_col[r] = in_pixel;
      end else begin : g_old
         assign new_col[r] = lb_rd[r];
      end
      for (genvar c = 0; c < KSIZE; c++) begin : g_col
         assign window[win_idx(r, c) +: PIX_W] = win_q[r][c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q     <= '0;
         row_q     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][KSIZE-1] <= new_col[r];
         end
         if (pos_c == COL_LAST) begin
            col_q <= '0;
            row_q <= (pos_r == ROW_LAST) ? '0 : pos_r + 1'b1;
         end else begin
            col_q <= pos_c + 1'b1;
            row_q <= pos_r;
         end
         // Only fully-interior positions produce a window
         out_valid <= (pos_r >= ROW_MIN) && (pos_c >= COL_MIN);
         out_last  <= (pos_r == ROW_LAST) && (pos_c == COL_LAST);
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_window_gen_5x5.sv
// tb/tb_window_gen_5x5.sv - scoreboard bench for window_gen_5x5 on an 8x8 image
module tb_window_gen_5x5;
   import img_pkg::*;

   localparam int W = 8;
   localparam int H = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_sof = 1'b0;
   logic [PIX_W-1:0] in_pixel = '0;
   logic             out_ready = 1'b1;
   logic             in_ready, out_valid, out_last;
   logic [WIN_W-1:0] window;

   always #5 clk = ~clk;

   window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .window    (window)
   );

   typedef struct {
      logic [WIN_W-1:0] w;
      logic             last;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIN_W-1:0] win_log[$];
   logic [7:0]       img[H][W];
   int               mr = 0, mc = 0;
   int               checks = 0, errors = 0;
   int               acc_cnt = 0, n_win = 0, n_last = 0, first_win_acc = -1;
   int               ready_mode = 0, bubble_pct = 0;
   bit               stall_done = 1'b0;

   task automatic check_bus(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: an image memory indexed by frame position; a window is the
   // 5x5 neighbourhood ending at the accepted pixel's position.
   function automatic void model_accept(input logic [7:0] pix, input bit sof);
      exp_t e;
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = pix;
      if (mr >= 4 && mc >= 4) begin
         e.w = '0;
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
               e.w[40*i + 8*j +: 8] = img[mr-4+i][mc-4+j];
         e.last = (mr == H - 1) && (mc == W - 1);
         exp_q.push_back(e);
      end
      mc++;
      if (mc == W) begin
         mc = 0;
         mr++;
         if (mr == H) mr = 0;
      end
   endfunction

   task automatic send_pixel(input logic [7:0] pix, input bit sof);
      int guard = 0;
      @(negedge clk);
      while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) @(negedge clk);
      in_valid = 1'b1;
      in_pixel = pix;
      in_sof   = sof;
      #1;
      while (!in_ready) begin
         guard++;
         if (guard > 1000) begin
            $display("FAIL accept_timeout actual=stalled required=accept");
            $fatal(1);
         end
         @(negedge clk);
         #1;
      end
      model_accept(pix, sof);
      @(posedge clk);
      acc_cnt++;
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input bit sof);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send_pixel(8'(8*r + c), sof && r == 0 && c == 0);
   endtask

   task automatic start_test();
      acc_cnt = 0;
      n_win = 0;
      n_last = 0;
      first_win_acc = -1;
      win_log.delete();
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check_int("drain_timeout", int'(t < 500), 1);
   endtask

   // Downstream readiness
   initial begin
      logic [WIN_W-1:0] saved;
      forever begin
         @(negedge clk);
         case (ready_mode)
            1: out_ready = ($urandom_range(99) < 60);
            2: begin
               if (!stall_done && out_valid) begin
                  saved = window;
                  out_ready = 1'b0;
                  for (int k = 0; k < 5; k++) begin
                     #2;
                     check_int("stall_in_ready", int'(in_ready), 0);
                     check_bus("stall_window", window, saved);
                     if (k < 4) @(negedge clk);
                  end
                  stall_done = 1'b1;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops and compares on every output transfer
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window actual=%h required=none", window);
            end else begin
               e = exp_q.pop_front();
               check_bus("window", window, e.w);
               check_int("out_last", int'(out_last), int'(e.last));
               n_win++;
               if (out_last) n_last++;
               if (first_win_acc < 0) first_win_acc = acc_cnt;
               win_log.push_back(window);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check_int("reset_out_valid", int'(out_valid), 0);
      check_int("reset_out_last", int'(out_last), 0);
      check_bus("reset_window", window, '0);
      check_int("reset_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      // 1: ramp frame, always ready
      start_test();
      send_frame(1'b1);
      drain();
      check_int("t1_first_latency", first_win_acc, 37);
      check_int("t1_windows", n_win, 16);
      check_int("t1_lasts", n_last, 1);
      if (win_log.size() == 16) begin
         check_int("t1_w00", int'(win_log[0][7:0]), 0);
         check_int("t1_w04", int'(win_log[0][39:32]), 4);
         check_int("t1_w40", int'(win_log[0][167:160]), 32);
         check_int("t1_w44", int'(win_log[0][199:192]), 36);
         check_int("t1_last_w44", int'(win_log[15][199:192]), 63);
      end

      // 2: five-cycle downstream stall
      ready_mode = 2;
      stall_done = 1'b0;
      start_test();
      send_frame(1'b1);
      drain();
      check_int("t2_stall_seen", int'(stall_done), 1);
      check_int("t2_windows", n_win, 16);

      // 3: random bubbles and random ready
      ready_mode = 1;
      bubble_pct = 30;
      start_test();
      send_frame(1'b1);
      drain();
      check_int("t3_windows", n_win, 16);

      // 4: two back-to-back frames
      bubble_pct = 10;
      start_test();
      send_frame(1'b1);
      send_frame(1'b1);
      drain();
      check_int("t4_windows", n_win, 32);
      check_int("t4_lasts", n_last, 2);
      if (win_log.size() == 32) check_bus("t4_frame2_first", win_log[16], win_log[0]);

      // 5: reset after 20 accepts, then a frame without sof
      ready_mode = 0;
      bubble_pct = 0;
      start_test();
      for (int i = 0; i < 20; i++) send_pixel(8'(i + 100), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      mr = 0;
      mc = 0;
      exp_q.delete();
      #1;
      check_int("t5_rst_out_valid", int'(out_valid), 0);
      check_bus("t5_rst_window", window, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_test();
      send_frame(1'b0);
      drain();
      check_int("t5_first_latency", first_win_acc, 37);
      check_int("t5_windows", n_win, 16);

      // 6: sof on the 11th pixel resyncs the counters
      ready_mode = 1;
      start_test();
      for (int i = 0; i < 10; i++) send_pixel(8'(8*(i/8) + i%8 + 200), 1'b0);
      send_frame(1'b1);
      drain();
      check_int("t6_first_latency", first_win_acc - 11, 36);
      check_int("t6_windows", n_win, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
